// File: rtl/pcie_phy_pkg.sv
// Shared types for the PCIe PHY receive path: arbiter FSM states and source tags.
package pcie_phy_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWN_DLLP = 2'd1,
        OWN_TLP  = 2'd2
    } rx_arb_state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_DLLP = 2'd1,
        SRC_TLP  = 2'd2
    } rx_arb_src_e;

endpackage

// File: rtl/phy_rx_axis_skid_buffer.sv
// Two-entry AXIS skid buffer. The head entry drives the output directly, so every
// m_axis field comes straight from a flop.
module phy_rx_axis_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    logic [W-1:0] head_q, tail_q;
    logic [1:0]   cnt_q;
    logic         push, pop;

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = head_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else if (flush_i) begin
            cnt_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) head_q <= in_data;
                    else               tail_q <= in_data;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                // Push and pop together: occupancy unchanged, queue shifts by one.
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_q <= in_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/phy_rx_axis_arbiter.sv
// Packet-atomic DLLP/TLP merge onto the PHY receive stream, DLLP-first with a bounded
// DLLP streak. Optional statistics counters under PHY_RX_ARB_STATS_EN.
module phy_rx_axis_arbiter
    import pcie_phy_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int USER_WIDTH      = 5,
    parameter int MAX_DLLP_STREAK = 4
`ifdef PHY_RX_ARB_STATS_EN
    , parameter int STAT_WIDTH    = 16
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  link_up_i,
    input  logic [DATA_WIDTH-1:0] s_dllp_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_dllp_axis_tkeep,
    input  logic                  s_dllp_axis_tvalid,
    input  logic                  s_dllp_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_dllp_axis_tuser,
    output logic                  s_dllp_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_tlp_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tlp_axis_tkeep,
    input  logic                  s_tlp_axis_tvalid,
    input  logic                  s_tlp_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_tlp_axis_tuser,
    output logic                  s_tlp_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic                  m_axis_tready,
`ifdef PHY_RX_ARB_STATS_EN
    output logic [STAT_WIDTH-1:0] dllp_pkt_cnt_o,
    output logic [STAT_WIDTH-1:0] tlp_pkt_cnt_o,
    output logic [STAT_WIDTH-1:0] starve_cnt_o,
`endif
    output logic [1:0]            grant_o,
    output logic                  busy_o
);
    localparam int STREAK_W = $clog2(MAX_DLLP_STREAK + 1);
    localparam int BASE_W   = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;
`ifdef PHY_RX_ARB_STATS_EN
    localparam int PW = BASE_W + 2;
`else
    localparam int PW = BASE_W;
`endif

    rx_arb_state_e        state_q;
    logic [STREAK_W-1:0]  streak_q;
    logic                 link_q, arb_en, skid_ready;
    logic                 streak_max, pick_d, pick_t, own_d, own_t, acc_d, acc_t;
    logic [BASE_W-1:0]    in_base;
    logic [PW-1:0]        in_pay, out_pay;

    // Arbitration restarts one cycle after the link comes back.
    assign arb_en     = link_up_i & link_q & ~rst_i;
    assign streak_max = (streak_q == STREAK_W'(MAX_DLLP_STREAK));
    assign pick_t     = s_tlp_axis_tvalid & (~s_dllp_axis_tvalid | streak_max);
    assign pick_d     = s_dllp_axis_tvalid & ~pick_t;

    always_comb begin
        own_d = 1'b0;
        own_t = 1'b0;
        if (arb_en) begin
            case (state_q)
                IDLE:     begin own_d = pick_d; own_t = pick_t; end
                OWN_DLLP: own_d = 1'b1;
                OWN_TLP:  own_t = 1'b1;
                default:  ;
            endcase
        end
    end

    assign acc_d   = own_d & s_dllp_axis_tvalid & skid_ready;
    assign acc_t   = own_t & s_tlp_axis_tvalid & skid_ready;
    assign grant_o = {own_t, own_d};
    // Link down drains both sources without forwarding anything.
    assign s_dllp_axis_tready = ~rst_i & (~link_up_i | (own_d & skid_ready));
    assign s_tlp_axis_tready  = ~rst_i & (~link_up_i | (own_t & skid_ready));
    assign busy_o = (state_q != IDLE) | m_axis_tvalid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            streak_q <= '0;
            link_q   <= 1'b1;
        end else begin
            link_q <= link_up_i;
            if (!link_up_i) begin
                state_q  <= IDLE;
                streak_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (acc_d) begin
                            if (!s_dllp_axis_tlast) state_q <= OWN_DLLP;
                            if (!s_tlp_axis_tvalid) streak_q <= '0;
                            else if (!streak_max)   streak_q <= streak_q + STREAK_W'(1);
                        end else if (acc_t) begin
                            if (!s_tlp_axis_tlast) state_q <= OWN_TLP;
                            streak_q <= '0;
                        end
                    end
                    OWN_DLLP: if (acc_d && s_dllp_axis_tlast) state_q <= IDLE;
                    OWN_TLP:  if (acc_t && s_tlp_axis_tlast)  state_q <= IDLE;
                    default:  state_q <= IDLE;
                endcase
            end
        end
    end

    assign in_base = own_t ? {s_tlp_axis_tdata, s_tlp_axis_tkeep, s_tlp_axis_tlast, s_tlp_axis_tuser}
                           : {s_dllp_axis_tdata, s_dllp_axis_tkeep, s_dllp_axis_tlast, s_dllp_axis_tuser};
`ifdef PHY_RX_ARB_STATS_EN
    assign in_pay = {in_base, own_t ? 2'(SRC_TLP) : 2'(SRC_DLLP)};
`else
    assign in_pay = in_base;
`endif

    phy_rx_axis_skid_buffer #(.W(PW)) u_skid (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (~link_up_i),
        .in_data   (in_pay),
        .in_valid  (acc_d | acc_t),
        .in_ready  (skid_ready),
        .out_data  (out_pay),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = out_pay[PW-1 -: BASE_W];

`ifdef PHY_RX_ARB_STATS_EN
    logic [1:0] m_src;
    logic       m_done, forced;
    assign m_src  = out_pay[1:0];
    assign m_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    assign forced = (state_q == IDLE) & acc_t & s_dllp_axis_tvalid & streak_max;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dllp_pkt_cnt_o <= '0;
            tlp_pkt_cnt_o  <= '0;
            starve_cnt_o   <= '0;
        end else begin
            if (m_done && m_src == 2'(SRC_DLLP) && dllp_pkt_cnt_o != '1)
                dllp_pkt_cnt_o <= dllp_pkt_cnt_o + STAT_WIDTH'(1);
            if (m_done && m_src == 2'(SRC_TLP) && tlp_pkt_cnt_o != '1)
                tlp_pkt_cnt_o <= tlp_pkt_cnt_o + STAT_WIDTH'(1);
            if (forced && starve_cnt_o != '1)
                starve_cnt_o <= starve_cnt_o + STAT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_phy_rx_axis_arbiter.sv
// Scoreboard bench for phy_rx_axis_arbiter: per-source driver queues, per-source expected
// queues, packet-order log. Stats checks compile in with PHY_RX_ARB_STATS_EN.
module tb_phy_rx_axis_arbiter;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [4:0]  user;
        logic [3:0]  gap;
    } beat_t;

    logic        clk = 1'b0, rst_i = 1'b1, link_up = 1'b1, m_ready = 1'b1;
    logic [1:0]  sv = '0, sl = '0, rdy, grant;
    logic [31:0] sd [2];
    logic [3:0]  sk [2];
    logic [4:0]  su [2];
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic [4:0]  m_user;
    logic        m_valid, m_last, busy;
`ifdef PHY_RX_ARB_STATS_EN
    logic [15:0] dllp_cnt, tlp_cnt, starve_cnt;
`endif

    int n_chk = 0, n_fail = 0, cyc = 0, seq = 0, exp_dpk = 0, exp_tpk = 0;
    int acc_cnt [2];
    beat_t dq0[$], dq1[$];
    logic [63:0] eq0[$], eq1[$];
    int acc_cyc_q[$], out_cyc_q[$], ord_log[$];
    logic rnd_rdy = 1'b0, mon_in_pkt = 1'b0;
    int mon_src = 0;

    phy_rx_axis_arbiter dut (
        .clk_i(clk), .rst_i(rst_i), .link_up_i(link_up),
        .s_dllp_axis_tdata(sd[0]), .s_dllp_axis_tkeep(sk[0]), .s_dllp_axis_tvalid(sv[0]),
        .s_dllp_axis_tlast(sl[0]), .s_dllp_axis_tuser(su[0]), .s_dllp_axis_tready(rdy[0]),
        .s_tlp_axis_tdata(sd[1]), .s_tlp_axis_tkeep(sk[1]), .s_tlp_axis_tvalid(sv[1]),
        .s_tlp_axis_tlast(sl[1]), .s_tlp_axis_tuser(su[1]), .s_tlp_axis_tready(rdy[1]),
        .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tvalid(m_valid),
        .m_axis_tlast(m_last), .m_axis_tuser(m_user), .m_axis_tready(m_ready),
`ifdef PHY_RX_ARB_STATS_EN
        .dllp_pkt_cnt_o(dllp_cnt), .tlp_pkt_cnt_o(tlp_cnt), .starve_cnt_o(starve_cnt),
`endif
        .grant_o(grant), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Queue one packet on source s; only the first n_exp beats are expected downstream.
    task automatic add_pkt(input int s, input int len, input int gap0, input int n_exp);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = {s[0], 31'(seq)};
            seq++;
            b.keep = 4'($urandom_range(1, 15));
            b.user = 5'($urandom);
            b.last = (i == len - 1);
            b.gap  = (i == 0) ? 4'(gap0) : 4'd0;
            if (s == 0) dq0.push_back(b); else dq1.push_back(b);
            if (i < n_exp) begin
                if (s == 0) eq0.push_back({22'b0, b.data, b.keep, b.last, b.user});
                else        eq1.push_back({22'b0, b.data, b.keep, b.last, b.user});
                if (b.last) begin
                    if (s == 0) exp_dpk++; else exp_tpk++;
                end
            end
        end
    endtask

    task automatic drv(input int s);
        beat_t b;
        bit hs;
        int n;
        @(posedge clk);
        forever begin
            #1;
            if ((s == 0 && dq0.size() == 0) || (s == 1 && dq1.size() == 0)) begin
                sv[s] = 1'b0;
                @(posedge clk);
            end else begin
                if (s == 0) b = dq0.pop_front(); else b = dq1.pop_front();
                if (b.gap != 0) begin
                    sv[s] = 1'b0;
                    repeat (int'(b.gap)) @(posedge clk);
                    #1;
                end
                sv[s] = 1'b1; sd[s] = b.data; sk[s] = b.keep; sl[s] = b.last; su[s] = b.user;
                hs = 1'b0;
                n = 0;
                while (!hs && n < 4000) begin
                    @(negedge clk);
                    hs = rdy[s];
                    if (hs && s == 0) acc_cyc_q.push_back(cyc);
                    @(posedge clk);
                    n++;
                end
                if (!hs) chk("drv_timeout", 64'(n), 64'd0);
                acc_cnt[s]++;
            end
        end
    endtask

    initial drv(0);
    initial drv(1);

    initial forever begin
        @(posedge clk); #1;
        if (rnd_rdy) m_ready = 1'($urandom_range(0, 1));
    end

    // Output monitor: scoreboard pop, packet atomicity, stall stability.
    initial begin
        logic [63:0] got, held, e;
        logic stall_q;
        int s;
        stall_q = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            got = {22'b0, m_data, m_keep, m_last, m_user};
            if (stall_q && link_up && !rst_i)
                chk("stall_hold", {m_valid, got[62:0]}, {1'b1, held[62:0]});
            stall_q = m_valid && !m_ready;
            held = got;
            if (m_valid && m_ready) begin
                s = m_data[31] ? 1 : 0;
                out_cyc_q.push_back(cyc);
                if (mon_in_pkt) chk("atomic_src", 64'(s), 64'(mon_src));
                e = '1;
                if (s == 0 && eq0.size() != 0) e = eq0.pop_front();
                if (s == 1 && eq1.size() != 0) e = eq1.pop_front();
                chk(s == 0 ? "beat_dllp" : "beat_tlp", got, e);
                if (m_last) begin
                    mon_in_pkt = 1'b0;
                    ord_log.push_back(s);
                end else begin
                    mon_in_pkt = 1'b1;
                    mon_src = s;
                end
            end
        end
    end

    task automatic wait_done(input int lim);
        int n = 0;
        while ((dq0.size() != 0 || dq1.size() != 0 || eq0.size() != 0 || eq1.size() != 0
                || sv != 2'b00) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("done_in_time", 64'(n < lim), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int base, n;
        int ord_exp[11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        acc_cnt[0] = 0;
        acc_cnt[1] = 0;
        for (int i = 0; i < 2; i++) begin sd[i] = '0; sk[i] = '0; su[i] = '0; end

        // Reset values while rst_i is held.
        repeat (3) @(negedge clk);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_fields", {22'b0, m_data, m_keep, m_last, m_user}, 64'd0);
        chk("rst_grant_rdy", {60'b0, grant, rdy}, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_i = 1'b0;
        @(negedge clk);
        chk("idle_busy_grant", {61'b0, busy, grant}, 64'd0);

        // Three back-to-back 2-beat DLLP packets: 1-cycle latency, one beat per cycle.
        acc_cyc_q.delete(); out_cyc_q.delete();
        for (int p = 0; p < 3; p++) add_pkt(0, 2, 0, 2);
        @(negedge clk);
        chk("dllp_grant", 64'(grant), 64'd1);
        wait_done(200);
        chk("dllp_beats_out", 64'(out_cyc_q.size()), 64'd6);
        chk("dllp_beats_acc", 64'(acc_cyc_q.size()), 64'd6);
        if (out_cyc_q.size() == 6 && acc_cyc_q.size() == 6)
            for (int i = 0; i < 6; i++)
                chk("dllp_latency", 64'(out_cyc_q[i]), 64'(acc_cyc_q[0] + 1 + i));

        // Both sources continuously valid: streak limit forces every fifth grant to TLP.
        ord_log.delete();
        for (int p = 0; p < 9; p++) add_pkt(0, 1, 0, 1);
        for (int p = 0; p < 2; p++) add_pkt(1, 1, 0, 1);
        wait_done(300);
        chk("streak_pkts", 64'(ord_log.size()), 64'd11);
        if (ord_log.size() == 11)
            for (int i = 0; i < 11; i++) chk("streak_order", 64'(ord_log[i]), 64'(ord_exp[i]));
`ifdef PHY_RX_ARB_STATS_EN
        chk("starve_cnt", 64'(starve_cnt), 64'd2);
`endif

        // DLLP arrives while a 4-beat TLP owns the output: held off until TLP tlast.
        ord_log.delete();
        add_pkt(1, 4, 0, 4);
        add_pkt(0, 1, 2, 1);
        repeat (3) @(negedge clk);
        chk("own_tlp_rdy_b3", {62'b0, rdy}, 64'b10);
        chk("own_tlp_grant", {62'b0, grant}, 64'b10);
        @(negedge clk);
        chk("own_tlp_rdy_b4", {62'b0, rdy}, 64'b10);
        @(negedge clk);
        chk("dllp_after_tlp", {62'b0, rdy}, 64'b01);
        wait_done(200);
        chk("no_interleave_n", 64'(ord_log.size()), 64'd2);
        if (ord_log.size() == 2) chk("no_interleave", {62'b0, 1'(ord_log[0]), 1'(ord_log[1])}, 64'b10);

        // Single-beat DLLP and TLP together: IDLE stays, TLP granted the following cycle.
        add_pkt(0, 1, 0, 1);
        add_pkt(1, 1, 0, 1);
        @(negedge clk);
        chk("single_d_grant", {60'b0, grant, rdy}, 64'b0101);
        @(negedge clk);
        chk("single_t_grant", {60'b0, grant, rdy}, 64'b1010);
        wait_done(100);

        // Link drop at beat 3 of a 5-beat TLP: beats 1-2 delivered, rest drained silently.
        base = acc_cnt[1];
        add_pkt(1, 5, 0, 2);
        n = 0;
        while (acc_cnt[1] < base + 2 && n < 100) begin @(negedge clk); n++; end
        chk("link_wait", 64'(n < 100), 64'd1);
        link_up = 1'b0;
        @(negedge clk);
        chk("link_dn_valid", 64'(m_valid), 64'd0);
        chk("link_dn_rdy", {61'b0, busy, rdy}, 64'b011);
        repeat (3) @(negedge clk);
        link_up = 1'b1;
        mon_in_pkt = 1'b0;
        @(negedge clk);
        chk("relink_idle", {62'b0, m_valid, busy}, 64'd0);
        add_pkt(1, 2, 0, 2);
        wait_done(100);

        // 100 random packets from both sources with random downstream stalls.
        rnd_rdy = 1'b1;
        for (int p = 0; p < 100; p++)
            add_pkt($urandom_range(0, 1), $urandom_range(1, 4), $urandom_range(0, 2), 4);
        wait_done(8000);
        rnd_rdy = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("final_idle", {62'b0, m_valid, busy}, 64'd0);
`ifdef PHY_RX_ARB_STATS_EN
        chk("dllp_pkt_cnt", 64'(dllp_cnt), 64'(exp_dpk));
        chk("tlp_pkt_cnt", 64'(tlp_cnt), 64'(exp_tpk));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
